// File: rtl/mdl_bram_rd_streamer.sv
// Purpose: walks a contiguous BRAM address range on a start command and streams the words out (valid/ready + last).
// Latency: start in cycle N -> first read strobe N+1, first stream beat N+3, then 1 beat/cycle with ready high.
// Backpressure: reads are credit-limited so FIFO entries plus reads in flight never exceed 4; stalled beats hold data/last.
//
// Ports:
//   iSYS_CLK, iSYS_RSTn       clock, asynchronous active-low reset
//   iSTART, iBASE, iLEN       command (sampled only while idle)
//   oBUSY, oDONE              status: busy until the done pulse, one-cycle done
//   oEN, oWE, oADR, iDOUT     BRAM port (read-only use, 1-cycle read latency)
//   oTVALID, oTDATA, oTLAST, iTREADY   output stream

// Small generic FIFO: push is unconditional (caller guarantees room), pop on rd_vld & rd_rdy.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: none internally; occupancy is exported so the caller can meter pushes.
module mdl_bram_rd_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;

  assign pop    = rd_vld & rd_rdy;
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({wr_vld, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end
endmodule

module mdl_bram_rd_streamer #(
  parameter int PRM_DRAM = 32,
  parameter int PRM_ADDR = 12,
  parameter int PRM_LEN  = 13
) (
  input  logic                iSYS_CLK,
  input  logic                iSYS_RSTn,
  input  logic                iSTART,
  input  logic [PRM_ADDR-1:0] iBASE,
  input  logic [PRM_LEN-1:0]  iLEN,
  output logic                oBUSY,
  output logic                oDONE,
  output logic                oEN,
  output logic                oWE,
  output logic [PRM_ADDR-1:0] oADR,
  input  logic [PRM_DRAM-1:0] iDOUT,
  output logic                oTVALID,
  output logic [PRM_DRAM-1:0] oTDATA,
  output logic                oTLAST,
  input  logic                iTREADY
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [PRM_ADDR-1:0]  base;
  logic [PRM_LEN-1:0]   len;
  logic [PRM_LEN-1:0]   issued;
  logic [PRM_LEN-1:0]   popped;
  logic                 en_q;       // read issued last cycle: its word is on iDOUT now
  logic [2:0]           fifo_count;
  logic                 fifo_vld;
  logic [PRM_DRAM-1:0]  fifo_dat;
  logic                 start_ok;
  logic                 room;
  logic                 beat;

  assign start_ok = (state == S_IDLE) && iSTART;

  // Credit: words queued plus the one read in flight must leave a slot for a new read.
  assign room  = (fifo_count + {2'b00, en_q}) < 3'd4;
  assign oEN   = (state == S_RUN) && (issued != len) && room;
  assign oWE   = 1'b0;
  // Address arithmetic truncates to PRM_ADDR bits, so ranges wrap past the top of memory.
  assign oADR  = (state == S_RUN) ? (base + issued[PRM_ADDR-1:0]) : '0;
  assign oBUSY = (state != S_IDLE);

  // Gate data with valid so the stream bus reads 0 after reset regardless of FIFO storage.
  assign oTVALID = fifo_vld;
  assign oTDATA  = fifo_vld ? fifo_dat : '0;
  assign oTLAST  = fifo_vld && (popped == len - 1'b1);
  assign beat    = fifo_vld && iTREADY;

  mdl_bram_rd_fifo #(
    .W     (PRM_DRAM),
    .DEPTH (4)
  ) u_fifo (
    .clk    (iSYS_CLK),
    .rst_n  (iSYS_RSTn),
    .wr_vld (en_q),
    .wr_dat (iDOUT),
    .rd_rdy (iTREADY),
    .rd_vld (fifo_vld),
    .rd_dat (fifo_dat),
    .count  (fifo_count)
  );

  always_ff @(posedge iSYS_CLK or negedge iSYS_RSTn) begin
    if (!iSYS_RSTn) begin
      state  <= S_IDLE;
      base   <= '0;
      len    <= '0;
      issued <= '0;
      popped <= '0;
      en_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      en_q  <= oEN;
      if (start_ok) begin
        base   <= iBASE;
        len    <= iLEN;
        issued <= '0;
        popped <= '0;
      end else begin
        if (oEN)  issued <= issued + 1'b1;
        if (beat) popped <= popped + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    oDONE     = 1'b0;
    case (state)
      S_IDLE: begin
        if (iSTART) state_nxt = (iLEN == '0) ? S_FIN : S_RUN;
      end
      S_RUN: begin
        // Leave on the final issue; the last word cannot reach the stream before DRAIN.
        if (oEN && (issued == len - 1'b1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (beat && oTLAST) state_nxt = S_FIN;
      end
      S_FIN: begin
        oDONE     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule
